sram_arbiter_n: RTL and testbench

Parametrised N-client SRAM arbiter. It is the successor to the fixed 3-client IF/ME/DMA arbiter and sits between the core/DMA memory clients and the single-port SRAM controller. It adds selectable fixed-priority or round-robin arbitration, grant-time latching of client commands, a registered read-data response stage, and back-to-back grants.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/arb_picker.sv | 60 ++++++
 rtl/sram_arbiter_n.sv | 214 +++++++++++++++++++++
 tb/tb_sram_arbiter_n.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the SRAM arbiter family.
//   state_t   : arbiter FSM state encoding (IDLE / SERVE / RESP), 2 bits
//   ARB_FIXED : arbitration mode 0, highest requesting index wins
//   ARB_RR    : arbitration mode 1, round-robin starting after the pointer
//   id_width  : width of a client index, never narrower than 1 bit
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // A single client still needs a 1-bit index so that ports stay legal.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_picker.sv
// ---------------------------------------------------------------------------
// arb_picker
// Combinational N-way winner selection, shared with the bus crossbar.
// Ports:
//   req   [N]    : request vector
//   mask  [N]    : clients excluded from this pick
//   ptr   [ID_W] : last granted index (round-robin starts at ptr+1)
//   mode         : 0 = fixed priority (highest index wins), 1 = round-robin
//   win   [ID_W] : winning index (0 when nothing is eligible)
//   valid        : at least one eligible request
// ---------------------------------------------------------------------------
module arb_picker
    import mem_arb_pkg::*;
#(
    parameter int N    = 3,
    parameter int ID_W = id_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    mask,
    input  logic [ID_W-1:0] ptr,
    input  logic            mode,
    output logic [ID_W-1:0] win,
    output logic            valid
);

    logic [N-1:0]    elig;
    logic [ID_W-1:0] rr_pos [N];

    assign elig  = req & ~mask;
    assign valid = |elig;

    // rr_pos[k] is the (k+1)-th candidate in round-robin search order.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rr_pos
            assign rr_pos[gi] = ID_W'((int'(ptr) + gi + 1) % N);
        end
    endgenerate

    // Both loops let the preferred candidate be the last assignment:
    // fixed mode scans upward so the highest index sticks, round-robin
    // scans the search order backwards so the nearest candidate sticks.
    always_comb begin
        win = '0;
        if (mode) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (elig[rr_pos[k]]) begin
                    win = rr_pos[k];
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (elig[i]) begin
                    win = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/sram_arbiter_n.sv
// ---------------------------------------------------------------------------
// sram_arbiter_n
// N-client arbiter in front of a single-port SRAM controller. A winner's
// command is latched at grant time, the SRAM is driven until SRAM_ready,
// and the read data is returned through a registered one-cycle response
// stage. A new grant can be issued from the response cycle (back-to-back).
//
// Optional build macro: ARB_TIMEOUT_EN -- adds a SERVE watchdog of
// TIMEOUT_CYCLES cycles that aborts the access and flags cl_err.
//
// Ports:
//   clk, reset_n (async, active low)
//   cl_req/cl_we [N], cl_addr [N*ADDR_W], cl_wdata [N*DATA_W] : clients
//   cl_ready [N] one-hot pulse, cl_rdata, cl_err                : response
//   SRAM_req/we/addr/wdata out, SRAM_rdata/ready in             : SRAM side
//   grant_id : index of the currently granted client (debug)
// ---------------------------------------------------------------------------
module sram_arbiter_n
    import mem_arb_pkg::*;
#(
    parameter int NUM_CLIENTS    = 3,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ID_W           = id_width(NUM_CLIENTS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_CLIENTS-1:0]        cl_req,
    input  logic [NUM_CLIENTS-1:0]        cl_we,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] cl_wdata,
    output logic [NUM_CLIENTS-1:0]        cl_ready,
    output logic [DATA_W-1:0]             cl_rdata,
    output logic                          cl_err,
    output logic                          SRAM_req,
    output logic                          SRAM_we,
    output logic [ADDR_W-1:0]             SRAM_addr,
    output logic [DATA_W-1:0]             SRAM_wdata,
    input  logic [DATA_W-1:0]             SRAM_rdata,
    input  logic                          SRAM_ready,
    output logic [ID_W-1:0]               grant_id
);

    // Reject configurations the picker and index widths cannot represent.
    generate
        if (NUM_CLIENTS < 1 || NUM_CLIENTS > 8 || TIMEOUT_CYCLES < 1 ||
            (ARB_MODE != ARB_FIXED && ARB_MODE != ARB_RR)) begin : g_bad_cfg
            $error("sram_arbiter_n: unsupported parameter set");
        end
    endgenerate

    state_t                   state_reg,      state_next;
    logic                     sram_req_reg,   sram_req_next;
    logic                     sram_we_reg,    sram_we_next;
    logic [ADDR_W-1:0]        sram_addr_reg,  sram_addr_next;
    logic [DATA_W-1:0]        sram_wdata_reg, sram_wdata_next;
    logic [ID_W-1:0]          grant_reg,      grant_next;
    logic [ID_W-1:0]          ptr_reg,        ptr_next;
    logic [NUM_CLIENTS-1:0]   ready_reg,      ready_next;
    logic [DATA_W-1:0]        rdata_reg,      rdata_next;

`ifdef ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0]         timer_reg,      timer_next;
    logic                     err_reg,        err_next;
`endif

    logic [NUM_CLIENTS-1:0]   arb_mask;
    logic [ID_W-1:0]          pick_win;
    logic                     pick_valid;
    logic                     arb_mode;

    assign arb_mode = (ARB_MODE == ARB_RR);

    // In RESP the answered client still holds cl_req, so it is masked to
    // stop it from being re-granted before it has seen its ready pulse.
    always_comb begin
        arb_mask = '0;
        if (state_reg == RESP) begin
            arb_mask[grant_reg] = 1'b1;
        end
    end

    arb_picker #(
        .N    (NUM_CLIENTS),
        .ID_W (ID_W)
    ) u_picker (
        .req   (cl_req),
        .mask  (arb_mask),
        .ptr   (ptr_reg),
        .mode  (arb_mode),
        .win   (pick_win),
        .valid (pick_valid)
    );

    always_comb begin
        state_next      = state_reg;
        sram_req_next   = sram_req_reg;
        sram_we_next    = sram_we_reg;
        sram_addr_next  = sram_addr_reg;
        sram_wdata_next = sram_wdata_reg;
        grant_next      = grant_reg;
        ptr_next        = ptr_reg;
        ready_next      = '0;           // ready is a single-cycle pulse
        rdata_next      = rdata_reg;    // held until the next response
`ifdef ARB_TIMEOUT_EN
        timer_next      = timer_reg;
        err_next        = 1'b0;
`endif

        unique case (state_reg)
            IDLE, RESP: begin
                if (pick_valid) begin
                    state_next      = SERVE;
                    sram_req_next   = 1'b1;
                    sram_we_next    = cl_we[pick_win];
                    sram_addr_next  = cl_addr[pick_win*ADDR_W +: ADDR_W];
                    sram_wdata_next = cl_wdata[pick_win*DATA_W +: DATA_W];
                    grant_next      = pick_win;
                    if (arb_mode) begin
                        ptr_next = pick_win;
                    end
`ifdef ARB_TIMEOUT_EN
                    timer_next = '0;
`endif
                end else begin
                    state_next = IDLE;
                end
            end

            SERVE: begin
                if (SRAM_ready) begin
                    state_next            = RESP;
                    sram_req_next         = 1'b0;
                    rdata_next            = SRAM_rdata;
                    ready_next[grant_reg] = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                // timer_reg counts completed SERVE cycles, so this is the
                // TIMEOUT_CYCLES-th cycle without a ready.
                else if (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next            = RESP;
                    sram_req_next         = 1'b0;
                    rdata_next            = '0;
                    err_next              = 1'b1;
                    ready_next[grant_reg] = 1'b1;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
`endif
            end

            default: begin
                state_next    = IDLE;
                sram_req_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            sram_req_reg   <= 1'b0;
            sram_we_reg    <= 1'b0;
            sram_addr_reg  <= '0;
            sram_wdata_reg <= '0;
            grant_reg      <= '0;
            ptr_reg        <= ID_W'(NUM_CLIENTS - 1);
            ready_reg      <= '0;
            rdata_reg      <= '0;
`ifdef ARB_TIMEOUT_EN
            timer_reg      <= '0;
            err_reg        <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            sram_req_reg   <= sram_req_next;
            sram_we_reg    <= sram_we_next;
            sram_addr_reg  <= sram_addr_next;
            sram_wdata_reg <= sram_wdata_next;
            grant_reg      <= grant_next;
            ptr_reg        <= ptr_next;
            ready_reg      <= ready_next;
            rdata_reg      <= rdata_next;
`ifdef ARB_TIMEOUT_EN
            timer_reg      <= timer_next;
            err_reg        <= err_next;
`endif
        end
    end

    assign cl_ready   = ready_reg;
    assign cl_rdata   = rdata_reg;
    assign SRAM_req   = sram_req_reg;
    assign SRAM_we    = sram_we_reg;
    assign SRAM_addr  = sram_addr_reg;
    assign SRAM_wdata = sram_wdata_reg;
    assign grant_id   = grant_reg;
`ifdef ARB_TIMEOUT_EN
    assign cl_err     = err_reg;
`else
    assign cl_err     = 1'b0;
`endif

    // A granted client must keep requesting until it is answered.
    property p_req_held;
        @(posedge clk) disable iff (!reset_n)
            (state_reg == SERVE) |-> cl_req[grant_reg];
    endproperty
    a_req_held: assert property (p_req_held);

endmodule

// File: tb/tb_sram_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter_n
// Directed bench: instance 0 is fixed priority, instance 1 is round-robin.
// Both use 3 clients, 32-bit buses and TIMEOUT_CYCLES = 4. Inputs change and
// outputs are sampled 1 time unit after the rising clock edge.
// ---------------------------------------------------------------------------
module tb_sram_arbiter_n;

    localparam int NC = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk;
    logic              rst_n   [2];
    logic [NC-1:0]     req     [2];
    logic [NC-1:0]     we      [2];
    logic [NC*AW-1:0]  addr    [2];
    logic [NC*DW-1:0]  wdata   [2];
    logic [NC-1:0]     rdy     [2];
    logic [DW-1:0]     rdata   [2];
    logic              err     [2];
    logic              s_req   [2];
    logic              s_we    [2];
    logic [AW-1:0]     s_addr  [2];
    logic [DW-1:0]     s_wdata [2];
    logic [DW-1:0]     s_rdata [2];
    logic              s_rdy   [2];
    logic [1:0]        gid     [2];

    int checks_total  = 0;
    int checks_passed = 0;
    int grant_cnt [4];

    sram_arbiter_n #(
        .NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW),
        .ARB_MODE(0), .TIMEOUT_CYCLES(4)
    ) dut_fix (
        .clk(clk), .reset_n(rst_n[0]),
        .cl_req(req[0]), .cl_we(we[0]), .cl_addr(addr[0]), .cl_wdata(wdata[0]),
        .cl_ready(rdy[0]), .cl_rdata(rdata[0]), .cl_err(err[0]),
        .SRAM_req(s_req[0]), .SRAM_we(s_we[0]), .SRAM_addr(s_addr[0]),
        .SRAM_wdata(s_wdata[0]), .SRAM_rdata(s_rdata[0]), .SRAM_ready(s_rdy[0]),
        .grant_id(gid[0])
    );

    sram_arbiter_n #(
        .NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW),
        .ARB_MODE(1), .TIMEOUT_CYCLES(4)
    ) dut_rr (
        .clk(clk), .reset_n(rst_n[1]),
        .cl_req(req[1]), .cl_we(we[1]), .cl_addr(addr[1]), .cl_wdata(wdata[1]),
        .cl_ready(rdy[1]), .cl_rdata(rdata[1]), .cl_err(err[1]),
        .SRAM_req(s_req[1]), .SRAM_we(s_we[1]), .SRAM_addr(s_addr[1]),
        .SRAM_wdata(s_wdata[1]), .SRAM_rdata(s_rdata[1]), .SRAM_ready(s_rdy[1]),
        .grant_id(gid[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Completes one access that is already in SERVE in this cycle: checks the
    // latched command, inserts 'waits' wait cycles, returns 'rd' and checks
    // the registered response that follows. Ends in the RESP cycle.
    task automatic access(input int d, input int exp_gid, input logic [31:0] exp_addr,
                          input logic exp_we, input logic [31:0] exp_wdata,
                          input int waits, input logic [31:0] rd, input logic [2:0] exp_rdy);
        check("sram_req_on",  s_req[d],   1);
        check("grant_id",     gid[d],     exp_gid);
        check("sram_addr",    s_addr[d],  exp_addr);
        check("sram_we",      s_we[d],    exp_we);
        check("sram_wdata",   s_wdata[d], exp_wdata);
        check("no_early_rdy", rdy[d],     0);
        for (int w = 0; w < waits; w++) begin
            s_rdy[d] = 1'b0;
            tick();
            check("sram_req_wait",  s_req[d],  1);
            check("sram_addr_hold", s_addr[d], exp_addr);
            check("no_rdy_wait",    rdy[d],    0);
        end
        s_rdy[d]   = 1'b1;
        s_rdata[d] = rd;
        tick();
        s_rdy[d]   = 1'b0;
        s_rdata[d] = 32'hDEAD_BEEF;
        check("cl_ready",      rdy[d],   exp_rdy);
        check("cl_rdata",      rdata[d], rd);
        check("cl_err",        err[d],   0);
        check("sram_req_drop", s_req[d], 0);
        $display("dut%0d access gid=%0d addr=%08h we=%0d wdata=%08h waits=%0d rdata=%08h ready=%03b",
                 d, gid[d], s_addr[d], s_we[d], s_wdata[d], waits, rdata[d], rdy[d]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req[d] = '0; we[d] = '0; addr[d] = '0; wdata[d] = '0;
            s_rdata[d] = '0; s_rdy[d] = 1'b0;
        end
        for (int i = 0; i < 4; i++) grant_cnt[i] = 0;
        tick();
        tick();

        // ---------------- reset state ----------------
        check("rst_sram_req", s_req[0], 0);
        check("rst_cl_ready", rdy[0],   0);
        check("rst_grant_id", gid[0],   0);
        check("rst_cl_rdata", rdata[0], 0);
        check("rst_cl_err",   err[0],   0);
        check("rst_rr_req",   s_req[1], 0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        tick();
        check("idle_no_req", s_req[0], 0);

        // ---------------- fixed priority ----------------
        for (int i = 0; i < NC; i++) begin
            addr[0][i*AW +: AW]  = 32'h100 + 32'(i * 16);
            wdata[0][i*DW +: DW] = 32'hA0 + 32'(i);
        end
        we[0]  = 3'b100;
        req[0] = 3'b111;
        tick();
        access(0, 2, 32'h120, 1'b1, 32'hA2, 0, 32'h1111_2222, 3'b100);
        req[0][2] = 1'b0;
        tick();
        access(0, 1, 32'h110, 1'b0, 32'hA1, 1, 32'h3333_4444, 3'b010);
        req[0][1] = 1'b0;
        tick();
        access(0, 0, 32'h100, 1'b0, 32'hA0, 0, 32'h5555_6666, 3'b001);
        req[0][0] = 1'b0;
        tick();
        check("fix_rdy_clear", rdy[0],   0);
        check("fix_idle",      s_req[0], 0);
        check("fix_rdata_hold", rdata[0], 32'h5555_6666);
        // SRAM_ready outside SERVE must not produce a response.
        s_rdy[0] = 1'b1;
        tick();
        s_rdy[0] = 1'b0;
        check("stray_ready", rdy[0],   0);
        check("stray_req",   s_req[0], 0);

        // ---------------- read path with mid-access address change --------
        addr[0][1*AW +: AW] = 32'h40;
        we[0]  = 3'b000;
        req[0] = 3'b010;
        tick();
        addr[0][1*AW +: AW] = 32'h9999_0000;
        access(0, 1, 32'h40, 1'b0, 32'hA1, 2, 32'hCAFE_F00D, 3'b010);
        req[0] = 3'b000;
        tick();

        // ---------------- back-to-back with masking of the served client ---
        addr[0][0*AW +: AW]  = 32'h500;
        wdata[0][0*DW +: DW] = 32'h0BAD_C0DE;
        we[0]  = 3'b001;
        req[0] = 3'b011;
        tick();
        access(0, 1, 32'h9999_0000, 1'b0, 32'hA1, 0, 32'h7777_0001, 3'b010);
        tick();   // client 1 still requests through RESP; client 0 must win
        req[0][1] = 1'b0;
        access(0, 0, 32'h500, 1'b1, 32'h0BAD_C0DE, 0, 32'h7777_0002, 3'b001);
        req[0] = 3'b000;
        tick();
        check("b2b_idle", s_req[0], 0);

        // ---------------- reset in the middle of SERVE ----------------
        req[0] = 3'b001;
        tick();
        check("pre_rst_req", s_req[0], 1);
        rst_n[0] = 1'b0;
        s_rdy[0] = 1'b1;
        s_rdata[0] = 32'h1234_5678;
        #1;
        check("rst_async_req", s_req[0], 0);
        check("rst_async_rdy", rdy[0],   0);
        tick();
        check("rst_hold_rdy",   rdy[0],   0);
        check("rst_hold_rdata", rdata[0], 0);
        rst_n[0] = 1'b1;
        s_rdy[0] = 1'b0;
        tick();
        access(0, 0, 32'h500, 1'b1, 32'h0BAD_C0DE, 0, 32'h8888_0000, 3'b001);
        req[0] = 3'b000;
        tick();

        // ---------------- round-robin fairness ----------------
        for (int i = 0; i < NC; i++) begin
            addr[1][i*AW +: AW]  = 32'h200 + 32'(i * 4);
            wdata[1][i*DW +: DW] = 32'hC000_0000 + 32'(i);
        end
        we[1]  = 3'b010;
        req[1] = 3'b111;
        tick();
        for (int k = 0; k < 9; k++) begin
            int c;
            c = k % 3;
            grant_cnt[gid[1]]++;
            access(1, c, 32'h200 + 32'(c * 4), (c == 1), 32'hC000_0000 + 32'(c),
                   k % 2, 32'h1000 + 32'(k), 3'(1 << c));
            if (k == 8) req[1] = 3'b000;
            tick();
        end
        check("rr_idle",    s_req[1],     0);
        check("rr_cnt0",    grant_cnt[0], 3);
        check("rr_cnt1",    grant_cnt[1], 3);
        check("rr_cnt2",    grant_cnt[2], 3);

`ifdef ARB_TIMEOUT_EN
        // ---------------- watchdog abort ----------------
        req[1] = 3'b001;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("to_req_on", s_req[1], 1);
            check("to_no_rdy", rdy[1],   0);
            tick();
        end
        check("to_req_drop", s_req[1], 0);
        check("to_ready",    rdy[1],   3'b001);
        check("to_err",      err[1],   1);
        check("to_rdata",    rdata[1], 0);
        $display("dut1 timeout gid=%0d ready=%03b err=%0d rdata=%08h", gid[1], rdy[1], err[1], rdata[1]);
        req[1] = 3'b000;
        tick();
        check("to_err_clear", err[1], 0);
        check("to_rdy_clear", rdy[1], 0);
`else
        check("err_tied_low", err[1], 0);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
